uart_pkt_deframer: RTL and testbench

- Sits directly downstream of the UART RX FIFO read port. Pops received bytes and hunts for frames of the form SYNC, LEN, PAYLOAD[LEN], CSUM.
- Buffers the payload and verifies the checksum.
- Emits only checksum-valid payloads on a valid/ready byte stream with a last flag. Bad or stalled frames are dropped and reported by error pulses.

---
 rtl/uart_pkt_pkg.sv | 15 +
 rtl/uart_pkt_buffer.sv | 26 ++
 rtl/uart_pkt_deframer.sv | 173 +++++++++++++++++
 tb/tb_uart_pkt_deframer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared encodings and constants for the UART packet deframer.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_EMIT    = 3'd4
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         CSUM_W            = 8;

endpackage

// File: rtl/uart_pkt_buffer.sv
// Payload store: MAX_LEN x 8 register file, one synchronous write port and
// one asynchronous read port. Storage is not reset.
module uart_pkt_buffer #(
    parameter int MAX_LEN = 16,
    parameter int AW      = $clog2(MAX_LEN + 1)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] wr_idx,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [7:0]    rd_data
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge CLK) begin
        if (we && wr_idx < AW'(MAX_LEN)) mem[wr_idx[IW-1:0]] <= wr_data;
    end

    // rd_idx runs one past the last byte once the final byte is loaded
    assign rd_data = (rd_idx < AW'(MAX_LEN)) ? mem[rd_idx[IW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_pkt_deframer.sv
// Pops UART RX bytes, hunts for SYNC/LEN/PAYLOAD/CSUM frames and streams
// checksum-valid payloads out on a valid/ready byte interface.
module uart_pkt_deframer
    import uart_pkt_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 2_700_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] uart_rd_data,
    input  logic       uart_rd_avail,
    output logic       uart_rd_req,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       pkt_ok,
    output logic       err_csum,
    output logic       err_len,
    output logic       err_timeout,
    output logic       busy
);

    localparam int            LW        = $clog2(MAX_LEN + 1);
    localparam int            TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [LW-1:0]      len_q, len_d, idx_q, idx_d, rd_idx_q, rd_idx_d;
    logic [CSUM_W-1:0]  sum_q, sum_d, csum_chk;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [7:0]         m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic               pkt_ok_q, pkt_ok_d, err_csum_q, err_csum_d;
    logic               err_len_q, err_len_d, err_timeout_q, err_timeout_d;
    logic               consume, buf_we;
    logic [7:0]         buf_rd_data;

    assign consume  = uart_rd_req & uart_rd_avail;
    assign csum_chk = sum_q + uart_rd_data;

    uart_pkt_buffer #(.MAX_LEN(MAX_LEN), .AW(LW)) u_buf (
        .CLK     (CLK),
        .we      (buf_we),
        .wr_idx  (idx_q),
        .wr_data (uart_rd_data),
        .rd_idx  (rd_idx_q),
        .rd_data (buf_rd_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_HUNT;
            len_q         <= '0;
            idx_q         <= '0;
            rd_idx_q      <= '0;
            sum_q         <= '0;
            tcnt_q        <= '0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            pkt_ok_q      <= 1'b0;
            err_csum_q    <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            rd_idx_q      <= rd_idx_d;
            sum_q         <= sum_d;
            tcnt_q        <= tcnt_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            m_last_q      <= m_last_d;
            pkt_ok_q      <= pkt_ok_d;
            err_csum_q    <= err_csum_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        rd_idx_d      = rd_idx_q;
        sum_d         = sum_q;
        tcnt_d        = '0;
        m_data_d      = m_data_q;
        m_valid_d     = m_valid_q;
        m_last_d      = m_last_q;
        pkt_ok_d      = 1'b0;
        err_csum_d    = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        buf_we        = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (consume && uart_rd_data == SYNC_BYTE) state_d = ST_LEN;
            end
            ST_LEN, ST_PAYLOAD, ST_CSUM: begin
                if (!consume) begin
                    // a consume in the same cycle always beats the timeout
                    if (tcnt_q == TCNT_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = ST_HUNT;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end else if (state_q == ST_LEN) begin
                    if (uart_rd_data != 8'h00 && uart_rd_data <= 8'(MAX_LEN)) begin
                        len_d    = LW'(uart_rd_data);
                        sum_d    = uart_rd_data;
                        idx_d    = '0;
                        rd_idx_d = '0;
                        state_d  = ST_PAYLOAD;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end else if (state_q == ST_PAYLOAD) begin
                    buf_we = 1'b1;
                    sum_d  = csum_chk;
                    idx_d  = idx_q + LW'(1);
                    if (idx_q == len_q - LW'(1)) state_d = ST_CSUM;
                end else if (csum_chk == '0) begin
                    // preload byte 0 so m_valid rises the cycle after CSUM
                    m_data_d  = buf_rd_data;
                    m_valid_d = 1'b1;
                    m_last_d  = (len_q == LW'(1));
                    rd_idx_d  = LW'(1);
                    state_d   = ST_EMIT;
                end else begin
                    err_csum_d = 1'b1;
                    state_d    = ST_HUNT;
                end
            end
            ST_EMIT: begin
                if (m_ready) begin
                    if (m_last_q) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        pkt_ok_d  = 1'b1;
                        state_d   = ST_HUNT;
                    end else begin
                        m_data_d = buf_rd_data;
                        m_last_d = (rd_idx_q == len_q - LW'(1));
                        rd_idx_d = rd_idx_q + LW'(1);
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        uart_rd_req = (state_q == ST_HUNT) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
        busy        = (state_q != ST_HUNT);
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign pkt_ok      = pkt_ok_q;
    assign err_csum    = err_csum_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// Bench for uart_pkt_deframer: directed frames plus random streams checked
// against a frame-level parser of the byte stream.
module tb_uart_pkt_deframer;

    localparam int         MAX_LEN = 16;
    localparam int         TO      = 100;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int EV_LAST = 256, EV_OK = 512, EV_CSUM = 768, EV_LEN = 1024, EV_TO = 1280;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] uart_rd_data = 8'h00;
    logic       uart_rd_avail = 1'b0;
    logic       uart_rd_req;
    logic [7:0] m_data;
    logic       m_valid, m_last;
    logic       m_ready = 1'b1;
    logic       pkt_ok, err_csum, err_len, err_timeout, busy;

    int         nasrt = 0, nfail = 0;
    int         cyc = 0, valid_cycles = 0, last_consume = 0;
    bit         rnd_ready = 1'b0;
    logic [7:0] fifo[$];
    logic [7:0] stim[$];
    int         ev[$], ev_cyc[$], exp_ev[$];

    uart_pkt_deframer #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST),
        .uart_rd_data(uart_rd_data), .uart_rd_avail(uart_rd_avail), .uart_rd_req(uart_rd_req),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .pkt_ok(pkt_ok), .err_csum(err_csum), .err_len(err_len), .err_timeout(err_timeout),
        .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Observed event log: handshaken bytes and pulses, stamped with their cycle
    always @(negedge CLK) begin
        if (!RST) begin
            if (m_valid) valid_cycles <= valid_cycles + 1;
            if (m_valid && m_ready) begin
                ev.push_back(int'({m_last, m_data}));
                ev_cyc.push_back(cyc);
            end
            if (pkt_ok)      begin ev.push_back(EV_OK);   ev_cyc.push_back(cyc); end
            if (err_csum)    begin ev.push_back(EV_CSUM); ev_cyc.push_back(cyc); end
            if (err_len)     begin ev.push_back(EV_LEN);  ev_cyc.push_back(cyc); end
            if (err_timeout) begin ev.push_back(EV_TO);   ev_cyc.push_back(cyc); end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        uart_rd_avail = (fifo.size() > 0);
        uart_rd_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        stim.push_back(b);
        drive_fifo();
    endtask

    task automatic push_hex(input string s);
        for (int i = 0; i + 1 < s.len(); i += 3) push_byte(8'(s.substr(i, i + 1).atohex()));
    endtask

    task automatic step();
        logic will;
        will = uart_rd_req && uart_rd_avail;
        if (will) last_consume = cyc;
        @(posedge CLK);
        #1;
        if (will) void'(fifo.pop_front());
        drive_fifo();
        if (rnd_ready) m_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic run_idle(input string tag, input int budget);
        int n = 0;
        while ((fifo.size() > 0 || busy || m_valid) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, {31'd0, fifo.size() == 0 && !busy && !m_valid}, 32'd1);
        step();
        step();
    endtask

    task automatic begin_case();
        ev.delete();
        ev_cyc.delete();
        stim.delete();
    endtask

    // Frame-level parse of the whole stream; an unfinished frame ends in a timeout
    function automatic void build_expect();
        int i = 0, n = stim.size(), L, s;
        exp_ev.delete();
        while (i < n) begin
            if (stim[i] != SYNC) begin i++; continue; end
            i++;
            if (i >= n) begin exp_ev.push_back(EV_TO); break; end
            L = int'(stim[i]);
            i++;
            if (L < 1 || L > MAX_LEN) begin exp_ev.push_back(EV_LEN); continue; end
            if (i + L >= n) begin exp_ev.push_back(EV_TO); break; end
            s = L;
            for (int k = 0; k <= L; k++) s += int'(stim[i + k]);
            if (s % 256 == 0) begin
                for (int k = 0; k < L; k++)
                    exp_ev.push_back(int'(stim[i + k]) + ((k == L - 1) ? EV_LAST : 0));
                exp_ev.push_back(EV_OK);
            end else begin
                exp_ev.push_back(EV_CSUM);
            end
            i += L + 1;
        end
    endfunction

    task automatic compare_log(input string tag);
        build_expect();
        chk({tag, "_count"}, ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < ev.size(); i++)
            chk($sformatf("%s_ev%0d", tag, i), ev[i], exp_ev[i]);
    endtask

    task automatic push_frame(input int L, input bit good);
        int s = L;
        logic [7:0] b;
        push_byte(SYNC);
        push_byte(8'(L));
        for (int k = 0; k < L; k++) begin
            b = 8'($urandom_range(0, 255));
            s += int'(b);
            push_byte(b);
        end
        if (good) push_byte(8'((256 - s % 256) % 256));
        else      push_byte(8'((256 - s % 256 + int'($urandom_range(1, 255))) % 256));
    endtask

    initial begin
        int n, v0;
        logic [7:0] b;
        drive_fifo();
        repeat (3) step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_pulses", {pkt_ok, err_csum, err_len, err_timeout}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_req", uart_rd_req, 1);
        RST = 1'b0;
        step();

        // good frame, full-rate output
        begin_case();
        push_hex("A5 03 11 22 33 97");
        run_idle("good", 100);
        compare_log("good");
        chk("good_latency", ev_cyc[0], last_consume + 1);
        chk("good_b2_cyc", ev_cyc[1], ev_cyc[0] + 1);
        chk("good_b3_cyc", ev_cyc[2], ev_cyc[1] + 1);
        chk("good_ok_cyc", ev_cyc[3], ev_cyc[2] + 1);

        // bad checksum
        begin_case();
        v0 = valid_cycles;
        push_hex("A5 03 11 22 33 98");
        run_idle("csum", 100);
        compare_log("csum");
        chk("csum_no_valid", valid_cycles - v0, 0);
        chk("csum_busy", busy, 0);

        // length errors then a single-byte frame
        begin_case();
        push_hex("A5 00 A5 11 A5 01 5A A5");
        run_idle("len", 100);
        compare_log("len");

        // garbage plus backpressure on the first output byte
        begin_case();
        m_ready = 1'b0;
        push_hex("00 FF A5 02 A5 10 49");
        n = 0;
        while (!m_valid && n < 50) begin step(); n++; end
        chk("bp_first_valid", m_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_data%0d", i), m_data, 8'hA5);
            chk($sformatf("bp_valid%0d", i), m_valid, 1);
            chk($sformatf("bp_rdreq%0d", i), uart_rd_req, 0);
            step();
        end
        m_ready = 1'b1;
        run_idle("bp", 100);
        compare_log("bp");

        // inter-byte timeout then recovery
        begin_case();
        push_hex("A5 02 11");
        run_idle("to", 400);
        compare_log("to");
        chk("to_cycle", ev_cyc[0], last_consume + TO + 1);
        begin_case();
        push_hex("A5 01 5A A5");
        run_idle("to_rec", 100);
        compare_log("to_rec");

        // reset while the second of three bytes is on the output
        begin_case();
        push_hex("A5 03 11 22 33 97");
        n = 0;
        while (ev.size() < 1 && n < 50) begin step(); n++; end
        chk("mid_valid", m_valid, 1);
        chk("mid_data", m_data, 8'h22);
        m_ready = 1'b0;
        RST = 1'b1;
        step();
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        RST = 1'b0;
        m_ready = 1'b1;
        repeat (3) step();
        chk("mid_log_count", ev.size(), 1);
        begin_case();
        push_frame(4, 1'b1);
        run_idle("mid_rec", 100);
        compare_log("mid_rec");

        // random streams: garbage, good, bad-checksum and bad-length frames
        rnd_ready = 1'b1;
        for (int it = 0; it < 10; it++) begin
            begin_case();
            if (it == 0) push_frame(MAX_LEN, 1'b1);
            repeat ($urandom_range(1, 4)) begin
                case ($urandom_range(0, 3))
                    0: repeat ($urandom_range(1, 3)) begin
                           do b = 8'($urandom_range(0, 255)); while (b == SYNC);
                           push_byte(b);
                       end
                    1: push_frame(int'($urandom_range(1, MAX_LEN)), 1'b1);
                    2: push_frame(int'($urandom_range(1, MAX_LEN)), 1'b0);
                    default: begin
                        push_byte(SYNC);
                        push_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
                    end
                endcase
            end
            run_idle($sformatf("rnd%0d", it), 2000);
            compare_log($sformatf("rnd%0d", it));
        end
        rnd_ready = 1'b0;
        m_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

endmodule
